// File: rtl/game_round_ctrl_if.sv
// Strobe and status bundle between the game view FSM / HUD and game_round_ctrl.
// The master drives the FSM strobes and scoring events, and reads round status and quotas.
// The slave (game_round_ctrl) accepts the strobes and drives the status and quotas.
interface game_round_ctrl_if;
`ifdef GAME_ROUND_BONUS_TIME_EN
    logic        bonus_time;
`endif
    logic        timer_enable;
    logic        time_resetn;
    logic        level_up;
    logic        resetn_level;
    logic        score_valid;
    logic [9:0]  score_value;
    logic        game_end;
    logic        next_level;
    logic [6:0]  time_left;
    logic [3:0]  level;
    logic [11:0] score;
    logic [11:0] target_score;
    logic [4:0]  max_gold;
    logic [4:0]  max_stone;
    logic [4:0]  max_diamond;

    modport master (
`ifdef GAME_ROUND_BONUS_TIME_EN
        output bonus_time,
`endif
        output timer_enable, time_resetn, level_up, resetn_level,
        output score_valid, score_value,
        input  game_end, next_level, time_left, level, score, target_score,
        input  max_gold, max_stone, max_diamond
    );

    modport slave (
`ifdef GAME_ROUND_BONUS_TIME_EN
        input  bonus_time,
`endif
        input  timer_enable, time_resetn, level_up, resetn_level,
        input  score_valid, score_value,
        output game_end, next_level, time_left, level, score, target_score,
        output max_gold, max_stone, max_diamond
    );
endinterface

// File: rtl/game_round_ctrl.sv
// Round countdown, cumulative score, level and target bookkeeping with per-level object quotas.
// Registered outputs update one edge after their cause; the quotas follow level combinationally.
// No backpressure: every strobe is taken on the cycle it is presented. Optional GAME_ROUND_BONUS_TIME_EN adds bonus_time.
module game_round_ctrl #(
    parameter int TICK_DIV      = 50000000,
    parameter int ROUND_SECONDS = 60,
    parameter int BASE_TARGET   = 650,
    parameter int TARGET_STEP   = 300,
    parameter int MAX_LEVEL     = 9
`ifdef GAME_ROUND_BONUS_TIME_EN
    ,
    parameter int BONUS_SECONDS = 10
`endif
) (
    input  logic             clk,
    input  logic             resetn,
    game_round_ctrl_if.slave bus
);

    localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [6:0]    time_left;
    logic [3:0]    level;
    logic [11:0]   score;
    logic [11:0]   target_score;
    logic          game_end;
    logic          next_level;

    logic [12:0]   score_sum;
    logic [11:0]   score_next;
    logic [12:0]   target_sum;
    logic [11:0]   target_sat;
    logic          tick_hit;
    logic [6:0]    time_dec;
    logic [6:0]    time_run_next;
    logic          end_hit;
`ifdef GAME_ROUND_BONUS_TIME_EN
    logic [8:0]    bonus_sum;
`endif

    // Next-state helpers: saturating score/target sums and the countdown step in RUN.
    always_comb begin
        score_sum  = {1'b0, score} + {3'b000, bus.score_value};
        score_next = score;
        if (!bus.resetn_level)
            score_next = '0;
        else if (bus.score_valid && state != DONE)
            score_next = score_sum[12] ? 12'hFFF : score_sum[11:0];

        target_sum = {1'b0, target_score} + 13'(TARGET_STEP);
        target_sat = target_sum[12] ? 12'hFFF : target_sum[11:0];

        tick_hit      = (state == RUN) && bus.timer_enable && (tick_cnt == TICK_LAST);
        time_dec      = time_left - 7'd1;
        time_run_next = time_left;
        end_hit       = 1'b0;
`ifdef GAME_ROUND_BONUS_TIME_EN
        bonus_sum = {2'b00, time_left} + 9'(BONUS_SECONDS) - {8'd0, tick_hit};
        if (state == RUN && bus.bonus_time) begin
            // A bonus in the final-tick cycle rescues the round: no end this cycle.
            time_run_next = (bonus_sum > 9'd99) ? 7'd99 : bonus_sum[6:0];
        end else
`endif
        if (tick_hit) begin
            time_run_next = time_dec;
            end_hit       = (time_dec == 7'd0);
        end
    end

    // Round FSM plus score/level registers; time_resetn outranks any tick in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            time_left    <= 7'(ROUND_SECONDS);
            level        <= 4'd1;
            score        <= '0;
            target_score <= 12'(BASE_TARGET);
            game_end     <= 1'b0;
            next_level   <= 1'b0;
        end else begin
            score <= score_next;

            if (!bus.resetn_level) begin
                level        <= 4'd1;
                target_score <= 12'(BASE_TARGET);
            end else if (bus.level_up) begin
                if (level < 4'(MAX_LEVEL))
                    level <= level + 4'd1;
                target_score <= target_sat;
            end

            if (!bus.time_resetn) begin
                state      <= IDLE;
                tick_cnt   <= '0;
                time_left  <= 7'(ROUND_SECONDS);
                game_end   <= 1'b0;
                next_level <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.timer_enable)
                            state <= RUN;
                    end
                    RUN: begin
                        if (bus.timer_enable)
                            tick_cnt <= tick_hit ? '0 : tick_cnt + CW'(1);
                        time_left <= time_run_next;
                        if (end_hit) begin
                            state      <= DONE;
                            game_end   <= 1'b1;
                            next_level <= (score_next >= target_score);
                        end
                    end
                    default: begin
                        // DONE: hold until the round is restarted.
                    end
                endcase
            end
        end
    end

    assign bus.game_end     = game_end;
    assign bus.next_level   = next_level;
    assign bus.time_left    = time_left;
    assign bus.level        = level;
    assign bus.score        = score;
    assign bus.target_score = target_score;
    assign bus.max_gold     = {1'b0, level} + 5'd3;
    assign bus.max_stone    = {1'b0, level} + 5'd2;
    assign bus.max_diamond  = {2'b00, level[3:1]};

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed scenarios plus randomized strobes.
// Outputs are compared every cycle against a cycle-count based model of the round rules.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_game_round_ctrl;

    localparam int TD = 4;
    localparam int RS = 3;

    logic clk;
    logic resetn;
    game_round_ctrl_if bus();

    game_round_ctrl #(.TICK_DIV(TD), .ROUND_SECONDS(RS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Model: a round is a count of enabled RUN cycles; it ends after RS*TD of them.
    int m_run, m_end, m_ecnt, m_lvl, m_sc, m_tgt, m_nl;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int sn, tn, ln;
        if (!resetn) begin
            m_run = 0; m_end = 0; m_ecnt = 0; m_nl = 0;
            m_lvl = 1; m_sc = 0; m_tgt = 650;
        end else begin
            sn = m_sc;
            if (!bus.resetn_level) sn = 0;
            else if (bus.score_valid && !m_end) begin
                sn = m_sc + int'(bus.score_value);
                if (sn > 4095) sn = 4095;
            end
            tn = m_tgt;
            ln = m_lvl;
            if (!bus.resetn_level) begin
                ln = 1; tn = 650;
            end else if (bus.level_up) begin
                if (m_lvl < 9) ln = m_lvl + 1;
                tn = m_tgt + 300;
                if (tn > 4095) tn = 4095;
            end
            if (!bus.time_resetn) begin
                m_run = 0; m_end = 0; m_ecnt = 0; m_nl = 0;
            end else if (!m_run && !m_end) begin
                if (bus.timer_enable) m_run = 1;
            end else if (m_run && bus.timer_enable) begin
                m_ecnt++;
                if (m_ecnt == RS * TD) begin
                    m_run = 0;
                    m_end = 1;
                    m_nl  = (sn >= m_tgt) ? 1 : 0;
                end
            end
            m_sc = sn; m_tgt = tn; m_lvl = ln;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("game_end",     int'(bus.game_end),     m_end);
            chk("next_level",   int'(bus.next_level),   m_nl);
            chk("time_left",    int'(bus.time_left),    RS - m_ecnt / TD);
            chk("level",        int'(bus.level),        m_lvl);
            chk("score",        int'(bus.score),        m_sc);
            chk("target_score", int'(bus.target_score), m_tgt);
            chk("max_gold",     int'(bus.max_gold),     3 + m_lvl);
            chk("max_stone",    int'(bus.max_stone),    2 + m_lvl);
            chk("max_diamond",  int'(bus.max_diamond),  m_lvl / 2);
        end
    end

    task automatic idle_inputs();
        bus.timer_enable = 1'b0;
        bus.time_resetn  = 1'b1;
        bus.level_up     = 1'b0;
        bus.resetn_level = 1'b1;
        bus.score_valid  = 1'b0;
        bus.score_value  = 10'd0;
`ifdef GAME_ROUND_BONUS_TIME_EN
        bus.bonus_time   = 1'b0;
`endif
    endtask

    task automatic wait_end(input int budget, output int cycles);
        cycles = 0;
        while (!bus.game_end && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (!bus.game_end) chk("timeout_game_end", 0, 1);
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        idle_inputs();
        bus.time_resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_en = 1;
        resetn = 1'b1;
        @(negedge clk);
        // Reset values pinned by hand.
        chk("rst_time_left", int'(bus.time_left), 3);
        chk("rst_level", int'(bus.level), 1);
        chk("rst_target", int'(bus.target_score), 650);
        chk("rst_quota_gold", int'(bus.max_gold), 4);
        chk("rst_quota_stone", int'(bus.max_stone), 3);
        chk("rst_quota_diamond", int'(bus.max_diamond), 0);
        chk("rst_game_end", int'(bus.game_end), 0);

        // First round: 1 cycle to start, then 12 enabled cycles.
        bus.time_resetn  = 1'b1;
        bus.timer_enable = 1'b1;
        wait_end(30, n);
        chk("round1_cycles", n, 13);
        chk("round1_next_level", int'(bus.next_level), 0);
        chk("round1_time_left", int'(bus.time_left), 0);

        // Restart, score 500 twice, run out.
        bus.time_resetn = 1'b0;
        @(negedge clk);
        bus.time_resetn = 1'b1;
        bus.timer_enable = 1'b0;
        bus.score_valid = 1'b1;
        bus.score_value = 10'd500;
        repeat (2) @(negedge clk);
        bus.score_valid = 1'b0;
        bus.timer_enable = 1'b1;
        wait_end(30, n);
        chk("round2_score", int'(bus.score), 1000);
        chk("round2_next_level", int'(bus.next_level), 1);
        bus.score_valid = 1'b1;
        bus.score_value = 10'd5;
        @(negedge clk);
        bus.score_valid = 1'b0;
        @(negedge clk);
        chk("done_score_ignored", int'(bus.score), 1000);

        // Score on the exact final-tick cycle counts toward next_level.
        bus.time_resetn = 1'b0;
        bus.resetn_level = 1'b0;
        @(negedge clk);
        bus.time_resetn = 1'b1;
        bus.resetn_level = 1'b1;
        bus.timer_enable = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            bus.score_valid = (i == 13);
            bus.score_value = 10'd1023;
            @(negedge clk);
        end
        bus.score_valid = 1'b0;
        chk("final_tick_game_end", int'(bus.game_end), 1);
        chk("final_tick_next_level", int'(bus.next_level), 1);
        chk("final_tick_score", int'(bus.score), 1023);

        // Level saturation and quotas at MAX_LEVEL.
        bus.level_up = 1'b1;
        repeat (9) @(negedge clk);
        bus.level_up = 1'b0;
        chk("lvl9_level", int'(bus.level), 9);
        chk("lvl9_target", int'(bus.target_score), 3350);
        chk("lvl9_gold", int'(bus.max_gold), 12);
        chk("lvl9_stone", int'(bus.max_stone), 11);
        chk("lvl9_diamond", int'(bus.max_diamond), 4);
        bus.resetn_level = 1'b0;
        bus.level_up = 1'b1;
        @(negedge clk);
        bus.resetn_level = 1'b1;
        bus.level_up = 1'b0;
        chk("rl_beats_lu_level", int'(bus.level), 1);
        chk("rl_beats_lu_score", int'(bus.score), 0);

        // timer_enable low mid-second holds the countdown.
        bus.time_resetn = 1'b0;
        @(negedge clk);
        bus.time_resetn = 1'b1;
        bus.timer_enable = 1'b1;
        bus.score_valid = 1'b1;
        bus.score_value = 10'd77;
        @(negedge clk);
        bus.score_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.timer_enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_time_left", int'(bus.time_left), 3);
        bus.timer_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("resume_time_left", int'(bus.time_left), 2);
        wait_end(30, n);
        bus.time_resetn = 1'b0;
        @(negedge clk);
        bus.time_resetn = 1'b1;
        chk("restart_game_end", int'(bus.game_end), 0);
        chk("restart_time_left", int'(bus.time_left), 3);
        chk("restart_score", int'(bus.score), 77);

        // Randomized strobes, model-checked every cycle.
        for (int c = 0; c < 3000; c++) begin
            bus.timer_enable = ($urandom_range(3, 0) != 0);
            bus.time_resetn  = ($urandom_range(39, 0) != 0);
            bus.resetn_level = ($urandom_range(59, 0) != 0);
            bus.level_up     = ($urandom_range(29, 0) == 0);
            bus.score_valid  = ($urandom_range(3, 0) == 0);
            bus.score_value  = 10'($urandom_range(1023, 0));
            resetn           = ($urandom_range(499, 0) != 0);
            @(negedge clk);
        end
        resetn = 1'b1;
        idle_inputs();
        @(negedge clk);
        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
